// File: rtl/gray_rx_decoder.sv
// Gray-code receiver: two-flop synchroniser, Gray-to-binary decode, new-value
// pulse with signed step and single-bit-change checking.
//
// state | meaning
// INIT0 | sync chain filling after reset
// INIT1 | priming load of the reference value on the next edge
// RUN   | compare each synchronised sample against the previous one
module gray_rx_decoder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic [WIDTH-1:0] delta,
  output logic             step_err,
  output logic             sticky_err,
  output logic             primed
);

  typedef enum logic [1:0] {INIT0, INIT1, RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sync1, sync2;
  logic [WIDTH-1:0] gray_prev, gray_prev_nxt;
  logic [WIDTH-1:0] bin_nxt, delta_nxt, bin_dec, gray_diff;
  logic             valid_nxt, step_err_nxt, sticky_nxt, primed_nxt;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gray_in;
      sync2 <= sync1;
    end
  end

  assign bin_dec   = gray2bin(sync2);
  assign gray_diff = sync2 ^ gray_prev;

  always_comb begin
    state_nxt     = state;
    gray_prev_nxt = gray_prev;
    bin_nxt       = bin_out;
    delta_nxt     = '0;
    valid_nxt     = 1'b0;
    step_err_nxt  = 1'b0;
    primed_nxt    = primed;
    case (state)
      INIT0: state_nxt = INIT1;
      INIT1: begin
        // sync2 still holds its reset value here; sync1 is what sync2 becomes
        // on this edge, so the first RUN compare sees no spurious change.
        state_nxt     = RUN;
        gray_prev_nxt = sync1;
        bin_nxt       = gray2bin(sync1);
        primed_nxt    = 1'b1;
      end
      RUN: begin
        if (sync2 != gray_prev) begin
          gray_prev_nxt = sync2;
          bin_nxt       = bin_dec;
          delta_nxt     = bin_dec - bin_out;
          valid_nxt     = 1'b1;
          step_err_nxt  = (gray_diff & (gray_diff - 1'b1)) != '0;
        end
      end
      default: state_nxt = INIT0;
    endcase
    sticky_nxt = (state == RUN) ? ((sticky_err & ~err_clr) | step_err_nxt) : sticky_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= INIT0;
      gray_prev  <= '0;
      bin_out    <= '0;
      delta      <= '0;
      bin_valid  <= 1'b0;
      step_err   <= 1'b0;
      sticky_err <= 1'b0;
      primed     <= 1'b0;
    end else begin
      state      <= state_nxt;
      gray_prev  <= gray_prev_nxt;
      bin_out    <= bin_nxt;
      delta      <= delta_nxt;
      bin_valid  <= valid_nxt;
      step_err   <= step_err_nxt;
      sticky_err <= sticky_nxt;
      primed     <= primed_nxt;
    end
  end

endmodule

// File: tb/tb_gray_rx_decoder.sv
// Directed bench for gray_rx_decoder (WIDTH=4) with hand-computed expectations.
module tb_gray_rx_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] gray_in;
  logic       err_clr;
  logic [3:0] bin_out;
  logic       bin_valid;
  logic [3:0] delta;
  logic       step_err;
  logic       sticky_err;
  logic       primed;

  int n_checks = 0;
  int n_errors = 0;

  gray_rx_decoder #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .gray_in   (gray_in),
    .err_clr   (err_clr),
    .bin_out   (bin_out),
    .bin_valid (bin_valid),
    .delta     (delta),
    .step_err  (step_err),
    .sticky_err(sticky_err),
    .primed    (primed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a new Gray value and check the pulse that appears two edges after sampling.
  task automatic step(input string tag, input logic [3:0] g, input logic [3:0] exp_bin,
                      input logic [3:0] exp_delta, input logic exp_err);
    gray_in = g;
    tick();
    check({tag, " valid_t1"}, bin_valid, 1'b0);
    tick();
    check({tag, " valid_t2"}, bin_valid, 1'b0);
    tick();
    check({tag, " valid"}, bin_valid, 1'b1);
    check({tag, " bin"}, bin_out, exp_bin);
    check({tag, " delta"}, delta, exp_delta);
    check({tag, " step_err"}, step_err, exp_err);
  endtask

  initial begin
    int pulses;
    int pulse_at;
    rst     = 1'b1;
    gray_in = 4'b0000;
    err_clr = 1'b0;
    #2;
    check("rst bin_out", bin_out, 4'd0);
    check("rst valid", bin_valid, 1'b0);
    check("rst primed", primed, 1'b0);
    check("rst sticky", sticky_err, 1'b0);
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    check("prime0 primed", primed, 1'b1);
    check("prime0 valid", bin_valid, 1'b0);

    // Full count 1..15 then wrap to 0, every step a single-bit change.
    pulses = 0;
    for (int n = 1; n <= 16; n++) begin
      logic [3:0] b;
      b = 4'(n);
      step($sformatf("count%0d", n), b ^ (b >> 1), b, 4'd1, 1'b0);
      pulses += int'(bin_valid);
    end
    check("count pulses", pulses, 16);
    check("count sticky", sticky_err, 1'b0);

    // Backward step and multi-bit jump.
    step("g0001", 4'b0001, 4'd1, 4'd1, 1'b0);
    step("g0011", 4'b0011, 4'd2, 4'd1, 1'b0);
    step("back", 4'b0001, 4'd1, 4'hF, 1'b0);
    step("jump", 4'b0010, 4'd3, 4'd2, 1'b1);
    check("jump sticky", sticky_err, 1'b1);
    tick(); tick();
    check("jump err_pulse_end", step_err, 1'b0);
    check("jump sticky_hold", sticky_err, 1'b1);

    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr sticky", sticky_err, 1'b0);

    // Clear on the same edge as a new bad jump: the error must win.
    gray_in = 4'b0111;
    tick(); tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clrjump valid", bin_valid, 1'b1);
    check("clrjump bin", bin_out, 4'd5);
    check("clrjump step_err", step_err, 1'b1);
    check("clrjump sticky", sticky_err, 1'b1);
    tick();
    check("clrjump sticky_hold", sticky_err, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Latency and hold: single change, valid exactly once on the third tick.
    gray_in  = 4'b0101;
    pulses   = 0;
    pulse_at = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (bin_valid) begin
        pulses++;
        pulse_at = t;
      end
    end
    check("hold pulses", pulses, 1);
    check("hold pulse_at", pulse_at, 3);
    check("hold bin", bin_out, 4'd6);
    check("hold delta", delta, 4'd0);
    check("hold sticky", sticky_err, 1'b0);

    // Priming with a non-zero value held through reset release.
    rst     = 1'b1;
    gray_in = 4'b0110;
    tick();
    rst = 1'b0;
    tick();
    check("prime e1 primed", primed, 1'b0);
    tick();
    check("prime e2 primed", primed, 1'b1);
    tick();
    check("prime e3 bin", bin_out, 4'd4);
    check("prime e3 valid", bin_valid, 1'b0);
    check("prime e3 step_err", step_err, 1'b0);
    tick();
    check("prime e4 valid", bin_valid, 1'b0);

    // Mid-run reset while bin_valid is high.
    step("pre_rst", 4'b0111, 4'd5, 4'd1, 1'b0);
    rst     = 1'b1;
    gray_in = 4'b1010;
    #1;
    check("midrst bin", bin_out, 4'd0);
    check("midrst valid", bin_valid, 1'b0);
    check("midrst delta", delta, 4'd0);
    check("midrst primed", primed, 1'b0);
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    check("midrst bin_after", bin_out, 4'd12);
    check("midrst valid_after", bin_valid, 1'b0);
    check("midrst err_after", step_err, 1'b0);
    check("midrst sticky_after", sticky_err, 1'b0);
    check("midrst primed_after", primed, 1'b1);
    tick();
    check("midrst valid_later", bin_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
